pipelined_prefix_adder: RTL and testbench

PIPELINED_PREFIX_ADDER -- requirements
Module: pipelined_prefix_adder

---
 rtl/pipelined_prefix_adder.sv | 210 +++++++++++++++++++++
 tb/tb_pipelined_prefix_adder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_prefix_adder.sv
// pipelined_prefix_adder
//   Kogge-Stone parallel-prefix adder/subtractor with a valid/ready pipeline.
//   Stage 0 registers the operands (with B already inverted for subtract ops
//   and the effective carry-in resolved). log2(WIDTH) prefix levels follow,
//   each registered when PIPE=1 or purely combinational when PIPE=0. A final
//   stage forms the sum and the flags and registers them.
//   The whole pipeline freezes while the output holds a result the consumer
//   has not taken (stall = out_valid & ~out_ready).
//
// Parameters
//   WIDTH : operand width (8, 16, 32 or 64)
//   PIPE  : 1 = register after every prefix level, 0 = input/output regs only
//
// Ports
//   clk, rst_n          : rising-edge clock, async active-low reset
//   in_valid / in_ready : operand handshake (in_ready = ~stall)
//   a, b, op, cin       : operands; op 00 A+B, 01 A-B, 10 A+B+cin, 11 A+~B+cin
//   out_valid/out_ready : result handshake
//   sum, cout, ovf      : result, carry out, signed overflow
//   zero, neg           : sum == 0, sum[WIDTH-1]
module pipelined_prefix_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned PIPE  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int unsigned LEVELS = $clog2(WIDTH);

  logic stall;
  logic out_valid_d, out_valid_q;

  assign stall    = out_valid_q & ~out_ready;
  assign in_ready = ~stall;

  // ---------------------------------------------------------------------------
  // Stage 0: operand capture
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] a_d, a_q;
  logic [WIDTH-1:0] beff_d, beff_q;
  logic             cin_d, cin_q;
  logic             v0_d, v0_q;

  always_comb begin
    v0_d   = in_valid;
    a_d    = a;
    beff_d = op[0] ? ~b : b;
    unique case (op)
      2'b00:   cin_d = 1'b0;
      2'b01:   cin_d = 1'b1;
      default: cin_d = cin;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_q   <= 1'b0;
      a_q    <= '0;
      beff_q <= '0;
      cin_q  <= 1'b0;
    end else if (!stall) begin
      v0_q <= v0_d;
      if (v0_d) begin
        a_q    <= a_d;
        beff_q <= beff_d;
        cin_q  <= cin_d;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Prefix tree state per level.
  //   g_s[k][j] : group generate ending at bit position j-1 (index 0 = bit -1,
  //               the carry-in: generate if 1, kill if 0)
  //   p_s[k][i] : group propagate ending at bit position i (bit -1 never
  //               propagates, so it is not stored)
  //   x_s[k]    : half-sum bits a ^ beff carried alongside for the final xor
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   g_s [LEVELS+1];
  logic [WIDTH-1:0] p_s [LEVELS+1];
  logic [WIDTH-1:0] x_s [LEVELS+1];
  logic             v_s [LEVELS+1];

  assign g_s[0] = {a_q & beff_q, cin_q};
  assign p_s[0] = a_q ^ beff_q;
  assign x_s[0] = a_q ^ beff_q;
  assign v_s[0] = v0_q;

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int unsigned DIST = 32'd1 << k;

    logic [WIDTH:0]   pe;
    logic [WIDTH:0]   g_d;
    logic [WIDTH-1:0] p_d;
    logic [WIDTH-1:0] x_d;
    logic             v_d;

    // Combine index j with index j-DIST; indices below DIST pass through.
    always_comb begin
      pe  = {p_s[k], 1'b0};
      g_d = g_s[k];
      p_d = p_s[k];
      x_d = x_s[k];
      v_d = v_s[k];
      for (int unsigned j = DIST; j <= WIDTH; j++) begin
        g_d[j]   = g_s[k][j] | (pe[j] & g_s[k][j-DIST]);
        p_d[j-1] = pe[j] & pe[j-DIST];
      end
    end

    if (PIPE != 0) begin : g_reg
      logic [WIDTH:0]   g_q;
      logic [WIDTH-1:0] p_q;
      logic [WIDTH-1:0] x_q;
      logic             v_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_q <= 1'b0;
          g_q <= '0;
          p_q <= '0;
          x_q <= '0;
        end else if (!stall) begin
          v_q <= v_d;
          if (v_d) begin
            g_q <= g_d;
            p_q <= p_d;
            x_q <= x_d;
          end
        end
      end

      assign g_s[k+1] = g_q;
      assign p_s[k+1] = p_q;
      assign x_s[k+1] = x_q;
      assign v_s[k+1] = v_q;
    end else begin : g_comb
      assign g_s[k+1] = g_d;
      assign p_s[k+1] = p_d;
      assign x_s[k+1] = x_d;
      assign v_s[k+1] = v_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Final stage: carries, sum, flags
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q;
  logic             ovf_d, ovf_q;
  logic             zero_d, zero_q;
  logic             neg_d, neg_q;

  // log2(WIDTH) levels span WIDTH indices, one short of the WIDTH+1 needed
  // to reach the carry-in from the top bit. The g | p & cin fold closes that
  // gap; for every lower bit the group already includes the carry-in and its
  // propagate is 0, so the extra term is inert there.
  always_comb begin
    carry       = g_s[LEVELS][WIDTH:1] | (p_s[LEVELS] & {WIDTH{g_s[LEVELS][0]}});
    sum_d       = x_s[LEVELS] ^ {carry[WIDTH-2:0], g_s[LEVELS][0]};
    cout_d      = carry[WIDTH-1];
    ovf_d       = carry[WIDTH-1] ^ carry[WIDTH-2];
    zero_d      = ~|sum_d;
    neg_d       = sum_d[WIDTH-1];
    out_valid_d = v_s[LEVELS];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
    end else if (!stall) begin
      out_valid_q <= out_valid_d;
      if (out_valid_d) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
        neg_q  <= neg_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign neg       = neg_q;

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
module tb_pipelined_prefix_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic [1:0]  op;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;
  logic        zero;
  logic        neg;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        o;
    logic        z;
    logic        n;
  } res_t;

  res_t expq[$];

  pipelined_prefix_adder #(.WIDTH(16), .PIPE(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero), .neg(neg)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on the operation definition.
  function automatic res_t model(input logic [15:0] ia, input logic [15:0] ib,
                                 input logic [1:0] iop, input logic icin);
    logic [15:0]     be;
    longint unsigned ci;
    longint unsigned tot;
    res_t            r;
    be  = (iop == 2'b01 || iop == 2'b11) ? ~ib : ib;
    ci  = (iop == 2'b00) ? 0 : (iop == 2'b01) ? 1 : longint'(icin);
    tot = longint'(ia) + longint'(be) + ci;
    r.s = tot[15:0];
    r.c = tot[16];
    r.o = (ia[15] == be[15]) && (r.s[15] != ia[15]);
    r.z = (r.s == 16'h0000);
    r.n = r.s[15];
    return r;
  endfunction

  function automatic res_t observed();
    res_t r;
    r = {sum, cout, ovf, zero, neg};
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = '0; cin = 1'b0;
    out_ready = 1'b1;
    #2;
    n_checks++;
    if ({out_valid, in_ready, observed()} !== {1'b0, 1'b1, 20'h0}) begin
      n_fail++;
      $display("FAIL reset_state: got valid=%b ready=%b res=%h, want valid=0 ready=1 res=00000",
               out_valid, in_ready, observed());
    end
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic test_single(input string name, input logic [15:0] ia, input logic [15:0] ib,
                             input logic [1:0] iop, input logic icin, input res_t want);
    int   lat;
    res_t ref_r;
    in_valid = 1'b1; a = ia; b = ib; op = iop; cin = icin; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    n_checks++;
    if (lat !== 6) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d cycles, want 6", name, lat);
    end
    n_checks++;
    if (observed() !== want) begin
      n_fail++;
      $display("FAIL %s_result: got %h, want %h", name, observed(), want);
    end
    ref_r = model(ia, ib, iop, icin);
    n_checks++;
    if (observed() !== ref_r) begin
      n_fail++;
      $display("FAIL %s_model: got %h, model %h", name, observed(), ref_r);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_drain: out_valid got %b, want 0", name, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int wait_c;
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1; a = 16'(i); b = 16'(i); op = 2'b00; cin = 1'b0;
      step();
    end
    in_valid = 1'b0;
    wait_c = 0;
    while (!out_valid && wait_c < 20) begin
      step();
      wait_c++;
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({out_valid, in_ready, sum} !== {1'b1, 1'b0, 16'h0002}) begin
        n_fail++;
        $display("FAIL b2b_stall: got valid=%b ready=%b sum=%h, want valid=1 ready=0 sum=0002",
                 out_valid, in_ready, sum);
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    for (int i = 1; i <= 3; i++) begin
      n_checks++;
      if ({out_valid, sum} !== {1'b1, 16'(2 * i)}) begin
        n_fail++;
        $display("FAIL b2b_release: got valid=%b sum=%h, want valid=1 sum=%h",
                 out_valid, sum, 16'(2 * i));
      end
      step();
    end
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain: out_valid got %b, want 0", out_valid);
    end
  endtask

  task automatic test_reset_in_flight();
    int wait_c;
    int seen;
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; a = 16'(i * 16'h0111); b = 16'h0101; op = 2'b00; cin = 1'b0;
      step();
    end
    in_valid = 1'b0;
    wait_c = 0;
    while (!out_valid && wait_c < 20) begin
      step();
      wait_c++;
    end
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL flight_fill: out_valid got %b, want 1", out_valid);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, in_ready, observed()} !== {1'b0, 1'b1, 20'h0}) begin
      n_fail++;
      $display("FAIL flight_reset: got valid=%b ready=%b res=%h, want valid=0 ready=1 res=00000",
               out_valid, in_ready, observed());
    end
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid) seen++;
      step();
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL flight_discard: got %0d stale results, want 0", seen);
    end
  endtask

  task automatic test_random();
    int   issued;
    int   cyc;
    res_t want;
    issued = 0;
    cyc = 0;
    expq.delete();
    while ((issued < 1000 || expq.size() > 0) && cyc < 30000) begin
      out_ready = ($urandom % 4) != 0;
      if (issued < 1000 && ($urandom % 4) != 0) begin
        in_valid = 1'b1;
        a = 16'($urandom); b = 16'($urandom);
        op = 2'($urandom); cin = 1'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && out_ready) begin
        n_checks++;
        if (expq.size() == 0) begin
          n_fail++;
          $display("FAIL random_extra: got %h, want no result", observed());
        end else begin
          want = expq.pop_front();
          if (observed() !== want) begin
            n_fail++;
            $display("FAIL random_result: got %h, want %h", observed(), want);
          end
        end
      end
      if (in_valid && in_ready) begin
        expq.push_back(model(a, b, op, cin));
        issued++;
      end
      step();
      cyc++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (issued !== 1000 || expq.size() !== 0) begin
      n_fail++;
      $display("FAIL random_complete: got issued=%0d pending=%0d, want 1000 and 0",
               issued, expq.size());
    end
  endtask

  initial begin
    test_reset();
    test_single("add_wrap", 16'hFFFF, 16'h0001, 2'b00, 1'b0, {16'h0000, 1'b1, 1'b0, 1'b1, 1'b0});
    test_single("sub_ovf",  16'h8000, 16'h0001, 2'b01, 1'b0, {16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0});
    test_single("add_ovf",  16'h7FFF, 16'h0001, 2'b00, 1'b0, {16'h8000, 1'b0, 1'b1, 1'b0, 1'b1});
    test_single("sbb_c0",   16'h1234, 16'h1234, 2'b11, 1'b0, {16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1});
    test_single("sbb_c1",   16'h1234, 16'h1234, 2'b11, 1'b1, {16'h0000, 1'b1, 1'b0, 1'b1, 1'b0});
    test_single("adc_c1",   16'h00FF, 16'h0100, 2'b10, 1'b1, {16'h0200, 1'b0, 1'b0, 1'b0, 1'b0});
    test_back_to_back();
    test_reset_in_flight();
    test_single("post_rst", 16'h0005, 16'h0003, 2'b01, 1'b0, {16'h0002, 1'b1, 1'b0, 1'b0, 1'b0});
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
